fetch_ctl: RTL and testbench

- Instruction-fetch stage and next-PC controller directly downstream of the program counter in the 2-stage MIPS core.
- Holds the program memory, which is read at the 10-bit PC count, and the IF/EX pipeline register.
- Decodes the instruction in IF/EX into the counter's select and offset inputs (sel_m1, sel_m2, inst_pm).
- Squashes the wrong-path fetch on taken control transfers and freezes the core on HALT.

---
 rtl/fetch_ctl.sv | 139 +++++++++++++
 tb/tb_fetch_ctl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctl.sv
// fetch_ctl: instruction-fetch stage and next-PC select for the 2-stage core.
// Holds program memory, the IF/EX register and the RUN/HALT control FSM.
module fetch_ctl #(
  parameter int ADDR_W = 10,
  parameter int INST_W = 32,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ex_zero,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [INST_W-1:0] ld_data,
  output logic [INST_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              sel_m1,
  output logic              sel_m2,
  output logic [ADDR_W-1:0] inst_pm,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  squash_cnt
);

  localparam logic [5:0] OP_SPEC = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [INST_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_valid;
  logic [CNT_W-1:0]  r_fcnt;
  logic [CNT_W-1:0]  r_scnt;

  logic [5:0]        w_op;
  logic [5:0]        w_fn;
  logic              w_sel_m1;
  logic              w_sel_m2;
  logic [ADDR_W-1:0] w_pm;
  logic              w_bubble;
  logic              w_load;
  logic [INST_W-1:0] w_fetch;

  assign w_op    = r_instr[31:26];
  assign w_fn    = r_instr[5:0];
  assign w_fetch = r_mem[pc];

  // Program image is only writable while the core is held in reset.
  always_ff @(posedge clk) begin
    if (rst && ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    w_sel_m1    = 1'b0;
    w_sel_m2    = 1'b0;
    w_pm        = '0;
    w_bubble    = 1'b0;
    w_load      = 1'b0;
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN: begin
        if (r_valid) begin
          if ((w_op == OP_BEQ && ex_zero) ||
              (w_op == OP_BNE && !ex_zero)) begin
            w_sel_m1 = 1'b1;
            w_pm     = r_instr[ADDR_W-1:0];
          end else if (w_op == OP_SPEC && w_fn == FN_JR) begin
            w_sel_m2 = 1'b1;
          end
        end
        if (w_sel_m1 || w_sel_m2) begin
          w_bubble = 1'b1;
        end else if (r_valid && w_op == OP_HALT) begin
          w_state_nxt = S_HALT;
        end else begin
          w_load = 1'b1;
        end
      end
      // Counter recirculates count+0, freezing the PC.
      S_HALT: begin
        w_sel_m1 = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_fcnt     <= '0;
      r_scnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_bubble) begin
        r_instr    <= '0;
        r_instr_pc <= pc;
        r_valid    <= 1'b0;
        if (r_scnt != '1) begin
          r_scnt <= r_scnt + CNT_W'(1);
        end
      end else if (w_load) begin
        r_instr    <= w_fetch;
        r_instr_pc <= pc;
        r_valid    <= 1'b1;
        if (r_fcnt != '1) begin
          r_fcnt <= r_fcnt + CNT_W'(1);
        end
      end
    end
  end

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign sel_m1      = w_sel_m1;
  assign sel_m2      = w_sel_m2;
  assign inst_pm     = w_pm;
  assign halted      = (r_state == S_HALT);
  assign fetch_cnt   = r_fcnt;
  assign squash_cnt  = r_scnt;

endmodule

// File: tb/tb_fetch_ctl.sv
// tb_fetch_ctl: reference-model bench for fetch_ctl.
// The bench also plays the program counter, driven from the model's selects.
module tb_fetch_ctl;

  localparam int AW    = 10;
  localparam int IW    = 32;
  localparam int DEPTH = 1024;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          ex_zero;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [IW-1:0] ld_data;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          sel_m1;
  logic          sel_m2;
  logic [AW-1:0] inst_pm;
  logic          halted;
  logic [CW-1:0] fetch_cnt;
  logic [CW-1:0] squash_cnt;

  always #5 clk = ~clk;

  fetch_ctl #(
    .ADDR_W(AW),
    .INST_W(IW),
    .DEPTH (DEPTH),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .ex_zero    (ex_zero),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .sel_m1     (sel_m1),
    .sel_m2     (sel_m2),
    .inst_pm    (inst_pm),
    .halted     (halted),
    .fetch_cnt  (fetch_cnt),
    .squash_cnt (squash_cnt)
  );

  logic [IW-1:0] m_mem  [DEPTH];
  logic [IW-1:0] filler [DEPTH];
  logic [IW-1:0] m_instr;
  logic [AW-1:0] m_ipc;
  logic          m_valid;
  logic          m_halt;
  int            m_fc;
  int            m_sc;
  logic          e_s1;
  logic          e_s2;
  logic [AW-1:0] e_pm;
  logic [AW-1:0] reg_val;
  logic [AW-1:0] pc_rst_val;
  int            n_vec;
  int            n_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_outputs();
    logic [5:0] op;
    op   = m_instr[31:26];
    e_s1 = 1'b0;
    e_s2 = 1'b0;
    e_pm = '0;
    if (m_halt) begin
      e_s1 = 1'b1;
    end else if (m_valid) begin
      if ((op == 6'h04 && ex_zero) || (op == 6'h05 && !ex_zero)) begin
        e_s1 = 1'b1;
        e_pm = m_instr[9:0];
      end else if (op == 6'h00 && m_instr[5:0] == 6'h08) begin
        e_s2 = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("instr", instr, m_instr);
    chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("sel_m1", 32'(sel_m1), 32'(e_s1));
    chk("sel_m2", 32'(sel_m2), 32'(e_s2));
    chk("inst_pm", 32'(inst_pm), 32'(e_pm));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("fetch_cnt", 32'(fetch_cnt), 32'(m_fc));
    chk("squash_cnt", 32'(squash_cnt), 32'(m_sc));
  endtask

  // One clock: compare at negedge+1, predict, then commit after the edge.
  task automatic cycle();
    logic [IW-1:0] n_instr;
    logic [AW-1:0] n_ipc;
    logic [AW-1:0] n_pc;
    logic          n_valid;
    logic          n_halt;
    int            n_fc;
    int            n_sc;
    logic          wr;
    logic [AW-1:0] wa;
    logic [IW-1:0] wd;
    #1;
    model_outputs();
    check_all();
    wr      = rst && ld_en;
    wa      = ld_addr;
    wd      = ld_data;
    n_instr = m_instr;
    n_ipc   = m_ipc;
    n_valid = m_valid;
    n_halt  = m_halt;
    n_fc    = m_fc;
    n_sc    = m_sc;
    if (rst) begin
      n_instr = '0;
      n_ipc   = '0;
      n_valid = 1'b0;
      n_halt  = 1'b0;
      n_fc    = 0;
      n_sc    = 0;
      n_pc    = pc_rst_val;
    end else begin
      if (m_halt) begin
        n_halt = 1'b1;
      end else if (e_s1 || e_s2) begin
        n_instr = '0;
        n_valid = 1'b0;
        n_ipc   = pc;
        n_sc    = (m_sc < CMAX) ? m_sc + 1 : m_sc;
      end else if (m_valid && m_instr[31:26] == 6'h3F) begin
        n_halt = 1'b1;
      end else begin
        n_instr = m_mem[pc];
        n_valid = 1'b1;
        n_ipc   = pc;
        n_fc    = (m_fc < CMAX) ? m_fc + 1 : m_fc;
      end
      n_pc = e_s2 ? reg_val : (e_s1 ? pc + e_pm : pc + 10'd1);
    end
    @(posedge clk);
    @(negedge clk);
    if (wr) m_mem[wa] = wd;
    m_instr = n_instr;
    m_ipc   = n_ipc;
    m_valid = n_valid;
    m_halt  = n_halt;
    m_fc    = n_fc;
    m_sc    = n_sc;
    pc      = n_pc;
  endtask

  task automatic do_reset(input logic [AW-1:0] rv);
    rst        = 1'b1;
    ld_en      = 1'b0;
    pc_rst_val = rv;
    pc         = rv;
    cycle();
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
    rst     = 1'b1;
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    cycle();
    ld_en   = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int          k;
    w = $urandom();
    k = $urandom_range(0, 15);
    case (k)
      0, 1, 2: w[31:26] = 6'h04;
      3, 4, 5: w[31:26] = 6'h05;
      6, 7: begin
        w[31:26] = 6'h00;
        w[5:0]   = 6'h08;
      end
      8: w[31:26] = 6'h3F;
      9: w[31:26] = 6'h00;
      default: w[31:26] = 6'h08;
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    pc         = '0;
    ex_zero    = 1'b0;
    reg_val    = '0;
    pc_rst_val = '0;
    m_instr    = '0;
    m_ipc      = '0;
    m_valid    = 1'b0;
    m_halt     = 1'b0;
    m_fc       = 0;
    m_sc       = 0;
    @(posedge clk);
    @(negedge clk);

    // Fill the whole program image with ADDI-type words.
    for (int i = 0; i < DEPTH; i++) begin
      w         = $urandom();
      w[31:26]  = 6'h08;
      filler[i] = w;
      load(AW'(i), w);
    end

    do_reset('0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fcnt", 32'(fetch_cnt), 32'd0);
    chk("rst_scnt", 32'(squash_cnt), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("seq_ipc", 32'(m_ipc), 32'(k));
    end
    chk("seq_fcnt4", 32'(m_fc), 32'd4);

    // BEQ taken, offset 5 from address 2.
    load(10'd2, 32'h1000_0005);
    do_reset('0);
    ex_zero = 1'b1;
    rst     = 1'b0;
    repeat (3) cycle();
    model_outputs();
    chk("beq_sel", 32'(e_s1), 32'd1);
    chk("beq_pm", 32'(e_pm), 32'd5);
    cycle();
    chk("beq_bubble", 32'(m_valid), 32'd0);
    cycle();
    chk("beq_tgt", 32'(m_ipc), 32'd8);
    chk("beq_sq", 32'(m_sc), 32'd1);

    // Same BEQ not taken.
    do_reset('0);
    ex_zero = 1'b0;
    rst     = 1'b0;
    repeat (3) cycle();
    model_outputs();
    chk("beqnt_sel", 32'(e_s1), 32'd0);
    repeat (2) cycle();
    chk("beqnt_ipc", 32'(m_ipc), 32'd4);
    chk("beqnt_sq", 32'(m_sc), 32'd0);

    // BNE with ex_zero=0 is taken.
    load(10'd2, 32'h1400_0005);
    do_reset('0);
    ex_zero = 1'b0;
    rst     = 1'b0;
    repeat (5) cycle();
    chk("bne_tgt", 32'(m_ipc), 32'd8);
    load(10'd2, filler[2]);

    // JR to 100.
    load(10'd1, 32'h03E0_0008);
    reg_val = 10'd100;
    do_reset('0);
    rst = 1'b0;
    repeat (2) cycle();
    model_outputs();
    chk("jr_sel", 32'(e_s2), 32'd1);
    cycle();
    chk("jr_bubble", 32'(m_valid), 32'd0);
    cycle();
    chk("jr_tgt", 32'(m_ipc), 32'd100);
    load(10'd1, filler[1]);

    // BEQ at 1023: target 1023+1+3 wraps to 3.
    load(10'd1023, 32'h1000_0003);
    ex_zero = 1'b1;
    do_reset(10'd1023);
    rst = 1'b0;
    cycle();
    chk("wrap_ipc", 32'(m_ipc), 32'd1023);
    repeat (2) cycle();
    chk("wrap_tgt", 32'(m_ipc), 32'd3);
    load(10'd1023, filler[1023]);

    // HALT at address 4.
    load(10'd4, 32'hFC00_0000);
    ex_zero = 1'b0;
    do_reset('0);
    rst = 1'b0;
    repeat (6) cycle();
    chk("halt_state", 32'(m_halt), 32'd1);
    chk("halt_ipc", 32'(m_ipc), 32'd4);
    repeat (20) cycle();
    chk("halt_pc", 32'(pc), 32'd6);
    ld_en   = 1'b1;
    ld_addr = '0;
    ld_data = 32'hDEAD_BEEF;
    cycle();
    ld_en = 1'b0;
    do_reset('0);
    chk("unhalt", 32'(halted), 32'd0);
    chk("unhalt_valid", 32'(instr_valid), 32'd0);
    chk("unhalt_fcnt", 32'(fetch_cnt), 32'd0);
    chk("unhalt_scnt", 32'(squash_cnt), 32'd0);
    rst = 1'b0;
    cycle();
    chk("ld_ignored", instr, filler[0]);
    load(10'd4, filler[4]);

    // JR-to-self loop drives both counters into saturation.
    load(10'd0, 32'h03E0_0008);
    reg_val = '0;
    do_reset('0);
    rst = 1'b0;
    repeat (150) cycle();
    chk("sat_sq", 32'(m_sc), 32'(CMAX));
    chk("sat_fc", 32'(m_fc), 32'(CMAX));
    chk("sat_dut", 32'(fetch_cnt), 32'(CMAX));
    load(10'd0, filler[0]);

    // Randomized episodes with mid-run resets and stray loads.
    for (int ep = 0; ep < 25; ep++) begin
      for (int j = 0; j < 8; j++) begin
        load(AW'($urandom()), rand_word());
      end
      do_reset(AW'($urandom()));
      for (int c = 0; c < 150; c++) begin
        ex_zero = 1'($urandom_range(0, 1));
        reg_val = AW'($urandom());
        rst     = ($urandom_range(0, 49) == 0);
        ld_en   = ($urandom_range(0, 7) == 0);
        ld_addr = AW'($urandom());
        ld_data = $urandom();
        cycle();
      end
      ld_en = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
